// File: rtl/html_tokenizer.sv
// Streaming HTML tokenizer: consumes one character per accepted cycle and
// produces tag-open/close, attribute, text, error and end tokens through a
// single-entry token register with ready/valid handshake.
module html_tokenizer (
  input  logic       clock,
  input  logic       reset,
  input  logic       state_enable,
  input  logic [7:0] in_char,
  input  logic       in_finished,
  output logic       pause,
  output logic       tok_valid,
  input  logic       tok_ready,
  output logic [2:0] tok_type,
  output logic [1:0] tok_tag,
  output logic [1:0] tok_attr,
  output logic [7:0] tok_value,
  output logic       done
);

  localparam int unsigned CHAR_W   = 8;
  localparam int unsigned NAME_MAX = 10;
  localparam int unsigned NAME_W   = CHAR_W * NAME_MAX;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned TYPE_W   = 3;
  localparam int unsigned ACC_W    = 12;
  localparam int unsigned TOK_W    = TYPE_W + ID_W + ID_W + CHAR_W;

  localparam logic [TYPE_W-1:0] TK_OPEN  = 3'd1;
  localparam logic [TYPE_W-1:0] TK_CLOSE = 3'd2;
  localparam logic [TYPE_W-1:0] TK_ATTR  = 3'd3;
  localparam logic [TYPE_W-1:0] TK_TEXT  = 3'd4;
  localparam logic [TYPE_W-1:0] TK_END   = 3'd5;
  localparam logic [TYPE_W-1:0] TK_ERROR = 3'd6;

  localparam logic [CHAR_W-1:0] CH_LT    = 8'h3C;
  localparam logic [CHAR_W-1:0] CH_GT    = 8'h3E;
  localparam logic [CHAR_W-1:0] CH_SLASH = 8'h2F;
  localparam logic [CHAR_W-1:0] CH_SP    = 8'h20;
  localparam logic [CHAR_W-1:0] CH_EQ    = 8'h3D;
  localparam logic [CHAR_W-1:0] CH_ZERO  = 8'h30;

  typedef enum logic [3:0] {
    S_TEXT, S_LT, S_NAME, S_CNAME, S_GAP, S_ANAME, S_AVAL, S_ESKIP, S_FIN
  } state_t;

  state_t              state;
  logic                cur_valid;
  logic [TOK_W-1:0]    tok_q;
  logic [NAME_W-1:0]   name_q;
  logic [LEN_W-1:0]    name_len;
  logic [CHAR_W-1:0]   val_q;
  logic                val_seen;
  logic [ID_W-1:0]     cur_tag;

  logic                consume;
  logic                is_lower;
  logic                is_digit;
  logic [CHAR_W-1:0]   digit;
  logic [ACC_W-1:0]    acc;
  logic [CHAR_W-1:0]   val_next;
  logic [NAME_W-1:0]   name_app;
  logic [LEN_W-1:0]    len_app;
  logic [ID_W-1:0]     tag_id;
  logic [ID_W-1:0]     attr_id;

  assign pause = tok_valid & ~tok_ready;
  assign {tok_type, tok_tag, tok_attr, tok_value} = tok_q;

  // Character classification, name shift-in and saturating decimal accumulate
  always_comb begin
    consume  = cur_valid & ~pause & (in_char != '0);
    is_lower = (in_char >= 8'h61) && (in_char <= 8'h7A);
    is_digit = (in_char >= CH_ZERO) && (in_char <= 8'h39);
    digit    = in_char - CH_ZERO;
    acc      = ACC_W'(val_q) * ACC_W'(10) + ACC_W'(digit[3:0]);
    val_next = (acc > ACC_W'(255)) ? 8'hFF : acc[CHAR_W-1:0];
    name_app = {name_q[NAME_W-CHAR_W-1:0], in_char};
    len_app  = (name_len > LEN_W'(NAME_MAX)) ? name_len : name_len + LEN_W'(1);
  end

  // Exact, case-sensitive name lookup; overlong names never match
  always_comb begin
    tag_id  = '0;
    attr_id = '0;
    if (name_len == LEN_W'(4) && name_q[31:0] == "body") tag_id = 2'd1;
    if (name_len == LEN_W'(1) && name_q[7:0] == "p")     tag_id = 2'd2;
    if (name_len == LEN_W'(10) && name_q == "background") attr_id = 2'd1;
    if (name_len == LEN_W'(5) && name_q[39:0] == "color") attr_id = 2'd2;
    if (name_len == LEN_W'(4) && name_q[31:0] == "size")  attr_id = 2'd3;
  end

  function automatic logic [TOK_W-1:0] mk_tok(input logic [TYPE_W-1:0] t,
                                               input logic [ID_W-1:0] g,
                                               input logic [ID_W-1:0] a,
                                               input logic [CHAR_W-1:0] v);
    return {t, g, a, v};
  endfunction

  // Parser FSM, input-valid flag, token register and completion flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_TEXT;
      cur_valid <= 1'b0;
      tok_valid <= 1'b0;
      tok_q     <= '0;
      done      <= 1'b0;
      name_q    <= '0;
      name_len  <= '0;
      val_q     <= '0;
      val_seen  <= 1'b0;
      cur_tag   <= '0;
    end else if (!state_enable) begin
      state     <= S_TEXT;
      cur_valid <= 1'b0;
      tok_valid <= 1'b0;
      tok_q     <= '0;
      done      <= 1'b0;
      name_q    <= '0;
      name_len  <= '0;
      val_q     <= '0;
      val_seen  <= 1'b0;
      cur_tag   <= '0;
    end else begin
      if (!pause) cur_valid <= ~in_finished;
      if (tok_valid && tok_ready) begin
        tok_valid <= 1'b0;
        if (state == S_FIN) done <= 1'b1;
      end
      if (consume) begin
        unique case (state)
          S_TEXT: begin
            if (in_char == CH_LT) state <= S_LT;
            else begin
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_TEXT, '0, '0, in_char);
            end
          end
          S_LT: begin
            if (in_char == CH_SLASH) begin
              state    <= S_CNAME;
              name_q   <= '0;
              name_len <= '0;
            end else if (is_lower) begin
              state    <= S_NAME;
              name_q   <= NAME_W'(in_char);
              name_len <= LEN_W'(1);
            end else begin
              state     <= S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_NAME: begin
            if (is_lower) begin
              name_q   <= name_app;
              name_len <= len_app;
            end else if (in_char == CH_SP || in_char == CH_GT) begin
              state     <= (in_char == CH_SP) ? S_GAP : S_TEXT;
              cur_tag   <= tag_id;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_OPEN, tag_id, '0, '0);
            end else begin
              state     <= S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_CNAME: begin
            if (is_lower) begin
              name_q   <= name_app;
              name_len <= len_app;
            end else if (in_char == CH_GT) begin
              state     <= S_TEXT;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_CLOSE, tag_id, '0, '0);
            end else begin
              state     <= S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_GAP: begin
            if (in_char == CH_SP) state <= S_GAP;
            else if (is_lower) begin
              state    <= S_ANAME;
              name_q   <= NAME_W'(in_char);
              name_len <= LEN_W'(1);
            end else if (in_char == CH_GT) state <= S_TEXT;
            else begin
              state     <= S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_ANAME: begin
            if (is_lower) begin
              name_q   <= name_app;
              name_len <= len_app;
            end else if (in_char == CH_EQ) begin
              state    <= S_AVAL;
              val_q    <= '0;
              val_seen <= 1'b0;
            end else begin
              state     <= S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_AVAL: begin
            if (is_digit) begin
              val_q    <= val_next;
              val_seen <= 1'b1;
            end else if ((in_char == CH_SP || in_char == CH_GT) && val_seen) begin
              state     <= (in_char == CH_SP) ? S_GAP : S_TEXT;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ATTR, cur_tag, attr_id, val_q);
            end else begin
              // An empty value closed by '>' has already ended the tag
              state     <= (in_char == CH_GT) ? S_TEXT : S_ESKIP;
              tok_valid <= 1'b1;
              tok_q     <= mk_tok(TK_ERROR, '0, '0, '0);
            end
          end
          S_ESKIP: begin
            if (in_char == CH_GT) state <= S_TEXT;
          end
          default: ;
        endcase
      end else if (!cur_valid && in_finished && !tok_valid && state != S_FIN) begin
        // Unfinished markup reports ERROR first; END follows from TEXT
        tok_valid <= 1'b1;
        if (state == S_TEXT) begin
          state <= S_FIN;
          tok_q <= mk_tok(TK_END, '0, '0, '0);
        end else begin
          state <= S_TEXT;
          tok_q <= mk_tok(TK_ERROR, '0, '0, '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_html_tokenizer.sv
// Self-checking bench for html_tokenizer: directed streams plus randomly
// assembled markup whose expected tokens are derived while it is built.
module tb_html_tokenizer;

  typedef struct packed {
    logic [2:0] ty;
    logic [1:0] tag;
    logic [1:0] attr;
    logic [7:0] val;
  } tok_t;

  localparam int T_OPEN  = 1;
  localparam int T_CLOSE = 2;
  localparam int T_ATTR  = 3;
  localparam int T_TEXT  = 4;
  localparam int T_END   = 5;
  localparam int T_ERROR = 6;

  logic       clock;
  logic       reset;
  logic       state_enable;
  logic [7:0] in_char;
  logic       in_finished;
  logic       pause;
  logic       tok_valid;
  logic       tok_ready;
  logic [2:0] tok_type;
  logic [1:0] tok_tag;
  logic [1:0] tok_attr;
  logic [7:0] tok_value;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_idx   = 0;
  int rmode    = 0;

  byte unsigned stim[$];
  tok_t         exp_q[$];
  tok_t         got_q[$];
  string        tag_names[6];
  string        attr_names[6];

  html_tokenizer dut (
    .clock       (clock),
    .reset       (reset),
    .state_enable(state_enable),
    .in_char     (in_char),
    .in_finished (in_finished),
    .pause       (pause),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_type    (tok_type),
    .tok_tag     (tok_tag),
    .tok_attr    (tok_attr),
    .tok_value   (tok_value),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int tag_id(input string n);
    if (n == "body") return 1;
    if (n == "p") return 2;
    return 0;
  endfunction

  function automatic int attr_id(input string n);
    if (n == "background") return 1;
    if (n == "color") return 2;
    if (n == "size") return 3;
    return 0;
  endfunction

  task automatic add_str(input string t);
    for (int i = 0; i < t.len(); i++) stim.push_back(t[i]);
  endtask

  task automatic expect_tok(input int ty, input int tg, input int at, input int v);
    tok_t t;
    t.ty   = 3'(ty);
    t.tag  = 2'(tg);
    t.attr = 2'(at);
    t.val  = 8'(v);
    exp_q.push_back(t);
  endtask

  function automatic void new_case();
    stim.delete();
    exp_q.delete();
  endfunction

  // Builds a random document from well-formed and malformed fragments
  task automatic build_random();
    int    nfrag;
    int    n;
    int    na;
    int    v;
    int    tid;
    string pool;
    string tn;
    string an;
    string sp;
    byte unsigned c;
    new_case();
    pool  = "abxyz019 .,";
    nfrag = $urandom_range(3, 8);
    for (int f = 0; f < nfrag; f++) begin
      case ($urandom_range(0, 6))
        0: begin
          n = $urandom_range(1, 4);
          for (int j = 0; j < n; j++) begin
            c = pool[$urandom_range(0, pool.len() - 1)];
            stim.push_back(c);
            expect_tok(T_TEXT, 0, 0, int'(c));
          end
        end
        1: stim.push_back(8'h00);
        2: begin
          tn  = tag_names[$urandom_range(0, 5)];
          tid = tag_id(tn);
          na  = $urandom_range(0, 2);
          add_str({"<", tn});
          expect_tok(T_OPEN, tid, 0, 0);
          for (int a = 0; a < na; a++) begin
            an = attr_names[$urandom_range(0, 5)];
            v  = $urandom_range(0, 999);
            sp = ($urandom_range(0, 1) == 1) ? "  " : " ";
            add_str({sp, an, "=", $sformatf("%0d", v)});
            expect_tok(T_ATTR, tid, attr_id(an), (v > 255) ? 255 : v);
          end
          if ($urandom_range(0, 1) == 1) add_str(" ");
          add_str(">");
        end
        3: begin
          tn = tag_names[$urandom_range(0, 5)];
          add_str({"</", tn, ">"});
          expect_tok(T_CLOSE, tag_id(tn), 0, 0);
        end
        4: begin
          add_str("<p =3>");
          expect_tok(T_OPEN, 2, 0, 0);
          expect_tok(T_ERROR, 0, 0, 0);
        end
        5: begin
          add_str("<P1>");
          expect_tok(T_ERROR, 0, 0, 0);
        end
        default: begin
          add_str("<p size=>");
          expect_tok(T_OPEN, 2, 0, 0);
          expect_tok(T_ERROR, 0, 0, 0);
        end
      endcase
    end
    expect_tok(T_END, 0, 0, 0);
  endtask

  // One clock: record accepted token, advance the reader model, set tok_ready
  task automatic cycle();
    logic p;
    p = pause;
    chk("pause", 32'(pause), 32'(tok_valid & ~tok_ready));
    if (tok_valid === 1'b1 && tok_ready === 1'b1)
      got_q.push_back(tok_t'({tok_type, tok_tag, tok_attr, tok_value}));
    @(posedge clock);
    #1;
    if (!p && state_enable) begin
      if (rd_idx < stim.size()) begin
        in_char = stim[rd_idx];
        rd_idx++;
      end
      in_finished = (rd_idx >= stim.size());
    end
    case (rmode)
      0:       tok_ready = 1'b1;
      1:       tok_ready = ~tok_ready;
      default: tok_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clock);
  endtask

  task automatic run_stream(input string name, input bit clear);
    int limit;
    if (clear) begin
      state_enable = 1'b0;
      @(posedge clock);
      #1;
      chk({name, " enable_clear_done"}, 32'(done), 32'd0);
      chk({name, " enable_clear_valid"}, 32'(tok_valid), 32'd0);
    end
    rd_idx       = 0;
    in_char      = 8'h00;
    in_finished  = (stim.size() == 0);
    state_enable = 1'b1;
    tok_ready    = 1'b1;
    got_q.delete();
    @(negedge clock);
    limit = 40 * stim.size() + 100;
    for (int c = 0; c < limit && done !== 1'b1; c++) cycle();
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s tok%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " tok_valid"}, 32'(tok_valid), 32'd0);
    chk({name, " tok_type"},  32'(tok_type),  32'd0);
    chk({name, " tok_tag"},   32'(tok_tag),   32'd0);
    chk({name, " tok_attr"},  32'(tok_attr),  32'd0);
    chk({name, " tok_value"}, 32'(tok_value), 32'd0);
    chk({name, " done"},      32'(done),      32'd0);
    chk({name, " pause"},     32'(pause),     32'd0);
  endtask

  task automatic load_reference_doc();
    new_case();
    add_str("<body background=3><p color=1 size=2>test</p></body>");
    stim.push_back(8'h00);
    expect_tok(T_OPEN, 1, 0, 0);
    expect_tok(T_ATTR, 1, 1, 3);
    expect_tok(T_OPEN, 2, 0, 0);
    expect_tok(T_ATTR, 2, 2, 1);
    expect_tok(T_ATTR, 2, 3, 2);
    expect_tok(T_TEXT, 0, 0, 8'h74);
    expect_tok(T_TEXT, 0, 0, 8'h65);
    expect_tok(T_TEXT, 0, 0, 8'h73);
    expect_tok(T_TEXT, 0, 0, 8'h74);
    expect_tok(T_CLOSE, 2, 0, 0);
    expect_tok(T_CLOSE, 1, 0, 0);
    expect_tok(T_END, 0, 0, 0);
  endtask

  initial begin
    tag_names  = '{"body", "p", "div", "background", "bodyy", "abcdefghijk"};
    attr_names = '{"background", "color", "size", "colour", "sizes", "backgrounds"};
    reset        = 1'b1;
    state_enable = 1'b0;
    in_char      = 8'h00;
    in_finished  = 1'b0;
    tok_ready    = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);

    rmode = 0;
    load_reference_doc();
    run_stream("doc_ready", 1'b1);

    rmode = 1;
    load_reference_doc();
    run_stream("doc_toggle", 1'b1);

    rmode = 0;
    new_case();
    add_str("<p size=999>");
    expect_tok(T_OPEN, 2, 0, 0);
    expect_tok(T_ATTR, 2, 3, 255);
    expect_tok(T_END, 0, 0, 0);
    run_stream("saturate", 1'b1);

    new_case();
    add_str("<p =3>x");
    expect_tok(T_OPEN, 2, 0, 0);
    expect_tok(T_ERROR, 0, 0, 0);
    expect_tok(T_TEXT, 0, 0, 8'h78);
    expect_tok(T_END, 0, 0, 0);
    run_stream("gap_error", 1'b1);

    new_case();
    add_str("<div>");
    expect_tok(T_OPEN, 0, 0, 0);
    expect_tok(T_END, 0, 0, 0);
    run_stream("unknown_tag", 1'b1);

    new_case();
    add_str("<p colour=4>");
    expect_tok(T_OPEN, 2, 0, 0);
    expect_tok(T_ATTR, 2, 0, 4);
    expect_tok(T_END, 0, 0, 0);
    run_stream("unknown_attr", 1'b1);

    new_case();
    expect_tok(T_END, 0, 0, 0);
    run_stream("empty", 1'b1);

    new_case();
    add_str("<p");
    expect_tok(T_ERROR, 0, 0, 0);
    expect_tok(T_END, 0, 0, 0);
    run_stream("unterminated", 1'b1);

    // Reset in the middle of a tag name, then a fresh stream
    new_case();
    add_str("<bo");
    state_enable = 1'b0;
    @(posedge clock);
    #1;
    rd_idx       = 0;
    in_char      = 8'h00;
    in_finished  = 1'b0;
    state_enable = 1'b1;
    tok_ready    = 1'b1;
    @(negedge clock);
    repeat (4) cycle();
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    new_case();
    add_str("<p>");
    expect_tok(T_OPEN, 2, 0, 0);
    expect_tok(T_END, 0, 0, 0);
    run_stream("after_reset", 1'b0);

    // A single low cycle of state_enable clears done
    state_enable = 1'b0;
    @(posedge clock);
    #1;
    chk("enable_drop done", 32'(done), 32'd0);
    state_enable = 1'b1;
    @(negedge clock);

    for (int r = 0; r < 20; r++) begin
      rmode = r % 3;
      build_random();
      run_stream($sformatf("rand%0d", r), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/html_tokenizer.md
HTML_TOKENIZER -- requirements
Module: html_tokenizer

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset: `clock` (1-bit input, rising-edge) and `reset` (1-bit input, asynchronous, active-high).
REQ-002 Ports, in order: name  direction  width  meaning.
- clock  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- state_enable  in  1  1 = parse session active; 0 = clear session state.
- in_char  in  8  current character from the char-stream reader.
- in_finished  in  1  reader has emitted its last character.
- pause  out  1  combinational back-pressure to the reader; while 1, the reader holds in_char.
- tok_valid  out  1  token register holds a token.
- tok_ready  in  1  downstream accepts the token this cycle.
- tok_type  out  3  token type: 0 NONE, 1 TAG_OPEN, 2 TAG_CLOSE, 3 ATTR, 4 TEXT, 5 END, 6 ERROR.
- tok_tag  out  2  tag id: 0 unknown, 1 body, 2 p.
- tok_attr  out  2  attribute id: 0 unknown, 1 background, 2 color, 3 size.
- tok_value  out  8  attribute value, or the character for TEXT tokens.
- done  out  1  END token has been accepted.

Function
REQ-003 pause SHALL equal tok_valid AND NOT tok_ready.
REQ-004 Internal flag cur_valid SHALL be updated on each clock edge as follows.
- state_enable=0: cleared.
- pause=0 and in_finished=0: set.
- pause=0 and in_finished=1: cleared.
- pause=1: held.
REQ-005 A character SHALL be consumed in a cycle where cur_valid=1 and pause=0; each character is consumed exactly once.
REQ-006 A consumed 0x00 SHALL be discarded with no state change.
REQ-007 Each consumed character SHALL produce at most one token, which is loaded into the token register on that edge.
REQ-008 The token register SHALL clear on the edge where tok_valid=1 and tok_ready=1, unless a new token is loaded on the same edge, in which case the new token replaces it.
REQ-009 The parser SHALL have these states: TEXT, LT, NAME, CNAME, GAP, ANAME, AVAL, ESKIP, FIN.
REQ-010 In TEXT, '<' SHALL go to LT; any other character SHALL emit TEXT with tok_value set to that character.
REQ-011 In LT, '/' SHALL go to CNAME; 'a'-'z' SHALL start NAME; any other character SHALL emit ERROR and go to ESKIP.
REQ-012 In NAME:
- 'a'-'z' appends to the name;
- ' ' emits TAG_OPEN and goes to GAP;
- '>' emits TAG_OPEN and goes to TEXT;
- any other character emits ERROR and goes to ESKIP.
REQ-013 In CNAME, 'a'-'z' SHALL append to the name; '>' SHALL emit TAG_CLOSE and go to TEXT; any other character SHALL emit ERROR and go to ESKIP.
REQ-014 In GAP:
- ' ' stays in GAP;
- 'a'-'z' starts ANAME;
- '>' goes to TEXT with no token;
- any other character emits ERROR and goes to ESKIP.
REQ-015 In ANAME, 'a'-'z' SHALL append to the name; '=' SHALL clear the value accumulator and go to AVAL; any other character SHALL emit ERROR and go to ESKIP.
REQ-016 In AVAL:
- '0'-'9': value = value*10 + digit, saturating at 255;
- ' ' emits ATTR and goes to GAP;
- '>' emits ATTR and goes to TEXT;
- any other character emits ERROR and goes to ESKIP.
REQ-017 AVAL with no digits terminated by ' ' or '>' SHALL emit ERROR.
REQ-018 In ESKIP, '>' SHALL go to TEXT; all other characters SHALL be discarded.
REQ-019 Name matching SHALL be case-sensitive and exact.
- Names longer than 10 characters SHALL map to id 0.
- Unmatched names SHALL map to id 0.
REQ-020 For ATTR tokens, tok_tag SHALL be the id of the enclosing open tag.
REQ-021 When cur_valid=0, in_finished=1, state_enable=1, and tok_valid=0, the END token SHALL be loaded and the state SHALL become FIN.
- This applies from any state; a non-TEXT state emits ERROR first, then END.
REQ-022 In FIN, no further tokens SHALL be produced; done SHALL set when END is accepted.
REQ-023 On a clock edge with state_enable=0, all state, tokens, and done SHALL clear synchronously, equivalent to reset.

Reset
REQ-024 While reset=1, the following SHALL hold:
- state = TEXT;
- cur_valid = 0;
- tok_valid = 0;
- tok_type, tok_tag, tok_attr, tok_value = 0;
- done = 0;
- pause = 0.
REQ-025 Reset asserted mid-tag SHALL discard the partial token; after release, parsing SHALL restart in TEXT.

Verification
REQ-026 Stream "<body background=3><p color=1 size=2>test</p></body>", 0x00 with tok_ready=1 SHALL produce, in order:
- OPEN(1);
- ATTR(1,1,3);
- OPEN(2);
- ATTR(2,2,1);
- ATTR(2,3,2);
- TEXT 't','e','s','t';
- CLOSE(2);
- CLOSE(1);
- END;
then done=1.
REQ-027 The same stream with tok_ready toggling 1/0 per cycle SHALL produce an identical token sequence, with no dropped or duplicated characters, and pause=1 exactly when tok_valid=1 and tok_ready=0.
REQ-028 "<p size=999>" SHALL produce OPEN(2) then ATTR(2,3,255).
REQ-029 "<p =3>x" SHALL produce OPEN(2), ERROR, TEXT 'x'.
REQ-030 "<div>" SHALL produce OPEN(0); "<p colour=4>" SHALL produce ATTR with tok_attr=0, tok_value=4.
REQ-031 Reset pulsed after "<bo" followed by "<p>" SHALL produce OPEN(2) only; state_enable dropped for one cycle SHALL clear done.
